// File: rtl/alu_issue_stage.sv
// Issue/writeback stage wrapped around an external combinational ALU, with RAW hazard handling.
// Build option FORWARD_EN: forward alu_result to hazarding sources instead of stalling one cycle.
module alu_issue_stage #(
   parameter  int WIDTH = 8,
   parameter  int NREG  = 4,
   localparam int AW    = (NREG > 1) ? $clog2(NREG) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [AW-1:0]    in_rd,
   input  logic [AW-1:0]    in_rs1,
   input  logic [AW-1:0]    in_rs2,
   input  logic             in_imm_sel,
   input  logic [WIDTH-1:0] in_imm,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_op,
   input  logic [WIDTH-1:0] alu_result,
   output logic             wb_valid,
   output logic [AW-1:0]    wb_addr,
   output logic [WIDTH-1:0] wb_data,
   input  logic [AW-1:0]    dbg_addr,
   output logic [WIDTH-1:0] dbg_data,
   output logic [15:0]      retire_cnt
);

   logic [WIDTH-1:0] rf [NREG];
   logic             e_valid;
   logic [AW-1:0]    e_rd;
   logic             hz_rs1;
   logic             hz_rs2;
   logic             accept;
   logic [WIDTH-1:0] opnd_a;
   logic [WIDTH-1:0] opnd_b;

   // rs2 only counts as a source when the immediate is not selected
   assign hz_rs1 = e_valid && (in_rs1 == e_rd);
   assign hz_rs2 = e_valid && !in_imm_sel && (in_rs2 == e_rd);

   always_comb begin
      opnd_a = rf[in_rs1];
      opnd_b = in_imm_sel ? in_imm : rf[in_rs2];
`ifdef FORWARD_EN
      in_ready = 1'b1;
      if (hz_rs1) opnd_a = alu_result;
      if (hz_rs2) opnd_b = alu_result;
`else
      in_ready = !(hz_rs1 || hz_rs2);
`endif
   end

   assign accept   = in_valid && in_ready;
   assign dbg_data = rf[dbg_addr];

   // Issue stage: latch operands for the ALU
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_valid <= 1'b0;
         e_rd    <= '0;
         alu_a   <= '0;
         alu_b   <= '0;
         alu_op  <= '0;
      end else if (accept) begin
         e_valid <= 1'b1;
         e_rd    <= in_rd;
         alu_a   <= opnd_a;
         alu_b   <= opnd_b;
         alu_op  <= in_op;
      end else begin
         e_valid <= 1'b0;
      end
   end

   // Writeback stage: commit the ALU result one edge after issue
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) rf[i] <= '0;
         wb_valid   <= 1'b0;
         wb_addr    <= '0;
         wb_data    <= '0;
         retire_cnt <= '0;
      end else begin
         wb_valid <= e_valid;
         if (e_valid) begin
            rf[e_rd]   <= alu_result;
            wb_addr    <= e_rd;
            wb_data    <= alu_result;
            retire_cnt <= retire_cnt + 16'd1;
         end
      end
   end

endmodule
